// File: rtl/axi_burst2iob.sv
// AXI4 slave to IOb master bridge. One AXI transaction in flight; every AXI beat
// becomes exactly one IOb access, with bursts, IDs and RLAST handled natively.
module axi_burst2iob #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int AXI_ID_W  = 1,
    parameter int AXI_LEN_W = 8
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  arst_i,

    input  logic [AXI_ID_W-1:0]   axi_awid_i,
    input  logic [ADDR_W-1:0]     axi_awaddr_i,
    input  logic [AXI_LEN_W-1:0]  axi_awlen_i,
    input  logic [2:0]            axi_awsize_i,
    input  logic [1:0]            axi_awburst_i,
    input  logic                  axi_awvalid_i,
    output logic                  axi_awready_o,

    input  logic [DATA_W-1:0]     axi_wdata_i,
    input  logic [DATA_W/8-1:0]   axi_wstrb_i,
    input  logic                  axi_wlast_i,
    input  logic                  axi_wvalid_i,
    output logic                  axi_wready_o,

    output logic [AXI_ID_W-1:0]   axi_bid_o,
    output logic [1:0]            axi_bresp_o,
    output logic                  axi_bvalid_o,
    input  logic                  axi_bready_i,

    input  logic [AXI_ID_W-1:0]   axi_arid_i,
    input  logic [ADDR_W-1:0]     axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]  axi_arlen_i,
    input  logic [2:0]            axi_arsize_i,
    input  logic [1:0]            axi_arburst_i,
    input  logic                  axi_arvalid_i,
    output logic                  axi_arready_o,

    output logic [AXI_ID_W-1:0]   axi_rid_o,
    output logic [DATA_W-1:0]     axi_rdata_o,
    output logic [1:0]            axi_rresp_o,
    output logic                  axi_rlast_o,
    output logic                  axi_rvalid_o,
    input  logic                  axi_rready_i,

    output logic                  iob_avalid_o,
    output logic [ADDR_W-1:0]     iob_addr_o,
    output logic [DATA_W-1:0]     iob_wdata_o,
    output logic [DATA_W/8-1:0]   iob_wstrb_o,
    input  logic                  iob_ready_i,
    input  logic                  iob_rvalid_i,
    input  logic [DATA_W-1:0]     iob_rdata_i
);

    localparam int         STRB_W   = DATA_W / 8;
    localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_W));

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_REQ, RD_WAIT, RD_DATA} state_t;

    state_t                state;
    logic [AXI_ID_W-1:0]   id;
    logic [ADDR_W-1:0]     addr;
    logic [ADDR_W-1:0]     next_addr;
    logic [ADDR_W-1:0]     step;
    logic [ADDR_W-1:0]     wrap_mask;
    logic [AXI_LEN_W-1:0]  len;
    logic [AXI_LEN_W-1:0]  cnt;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  err;
    logic                  prio_wr;
    logic                  last;
    logic                  sel_wr;
    logic                  sel_rd;
    logic                  w_beat;
    logic [DATA_W-1:0]     rdata;

    // Reserved burst type or a beat wider than the data bus cannot be served.
    function automatic logic bad_req(input logic [2:0] sz, input logic [1:0] bt);
        return (bt == 2'b11) || (sz > SIZE_MAX);
    endfunction

    assign sel_wr = axi_awvalid_i && (!axi_arvalid_i || prio_wr);
    assign sel_rd = axi_arvalid_i && (!axi_awvalid_i || !prio_wr);
    assign last   = (cnt == len);
    assign w_beat = (state == WR_DATA) && axi_wvalid_i && (err || iob_ready_i);

    always_comb begin
        step      = ADDR_W'(1) << size;
        wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        // NOTE: the default arm gives next_addr a value on every path, so no latch is inferred.
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default: next_addr = addr + step;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state   <= IDLE;
            id      <= '0;
            addr    <= '0;
            len     <= '0;
            size    <= '0;
            burst   <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            prio_wr <= 1'b1;
            rdata   <= '0;
        end else if (cke_i) begin
            case (state)
                IDLE: begin
                    if (sel_wr) begin
                        id    <= axi_awid_i;
                        addr  <= axi_awaddr_i;
                        len   <= axi_awlen_i;
                        size  <= axi_awsize_i;
                        burst <= axi_awburst_i;
                        cnt   <= '0;
                        err   <= bad_req(axi_awsize_i, axi_awburst_i);
                        if (axi_arvalid_i) prio_wr <= 1'b0;
                        state <= WR_DATA;
                    end else if (sel_rd) begin
                        id    <= axi_arid_i;
                        addr  <= axi_araddr_i;
                        len   <= axi_arlen_i;
                        size  <= axi_arsize_i;
                        burst <= axi_arburst_i;
                        cnt   <= '0;
                        err   <= bad_req(axi_arsize_i, axi_arburst_i);
                        if (axi_awvalid_i) prio_wr <= 1'b1;
                        state <= RD_REQ;
                    end
                end
                WR_DATA: begin
                    // Burst length always follows len; a wlast mismatch only poisons the response.
                    if (w_beat) begin
                        if (axi_wlast_i != last) err <= 1'b1;
                        if (last) begin
                            state <= WR_RESP;
                        end else begin
                            cnt  <= cnt + AXI_LEN_W'(1);
                            addr <= next_addr;
                        end
                    end
                end
                WR_RESP: begin
                    if (axi_bready_i) state <= IDLE;
                end
                RD_REQ: begin
                    if (err) begin
                        rdata <= '0;
                        state <= RD_DATA;
                    end else if (iob_ready_i) begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (iob_rvalid_i) begin
                        rdata <= iob_rdata_i;
                        state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (axi_rready_i) begin
                        if (last) begin
                            state <= IDLE;
                        end else begin
                            cnt   <= cnt + AXI_LEN_W'(1);
                            addr  <= next_addr;
                            state <= RD_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign axi_awready_o = (state == IDLE) && sel_wr;
    assign axi_arready_o = (state == IDLE) && sel_rd;
    assign axi_wready_o  = (state == WR_DATA) && (err || iob_ready_i);

    assign axi_bvalid_o  = (state == WR_RESP);
    assign axi_bid_o     = id;
    assign axi_bresp_o   = (axi_bvalid_o && err) ? 2'b10 : 2'b00;

    assign axi_rvalid_o  = (state == RD_DATA);
    assign axi_rid_o     = id;
    assign axi_rdata_o   = rdata;
    assign axi_rresp_o   = (axi_rvalid_o && err) ? 2'b10 : 2'b00;
    assign axi_rlast_o   = axi_rvalid_o && last;

    // Errored transactions never reach the IOb side.
    assign iob_avalid_o  = !err && (((state == WR_DATA) && axi_wvalid_i) || (state == RD_REQ));
    assign iob_addr_o    = addr;
    assign iob_wdata_o   = axi_wdata_i;
    assign iob_wstrb_o   = ((state == WR_DATA) && !err) ? axi_wstrb_i : '0;

endmodule

// File: tb/tb_axi_burst2iob.sv
// Self-checking bench for axi_burst2iob: a table of AXI transactions with hand-computed
// IOb addresses and responses, plus arbitration and mid-burst reset sequences.
`timescale 1ns/1ps
module tb_axi_burst2iob;

    localparam int TMO = 64;

    logic        clk_i = 1'b0;
    logic        cke_i, arst_i;
    logic [0:0]  axi_awid_i, axi_arid_i, axi_bid_o, axi_rid_o;
    logic [31:0] axi_awaddr_i, axi_araddr_i, axi_wdata_i, axi_rdata_o;
    logic [7:0]  axi_awlen_i, axi_arlen_i;
    logic [2:0]  axi_awsize_i, axi_arsize_i;
    logic [1:0]  axi_awburst_i, axi_arburst_i, axi_bresp_o, axi_rresp_o;
    logic        axi_awvalid_i, axi_awready_o, axi_arvalid_i, axi_arready_o;
    logic [3:0]  axi_wstrb_i, iob_wstrb_o;
    logic        axi_wlast_i, axi_wvalid_i, axi_wready_o;
    logic        axi_bvalid_o, axi_bready_i, axi_rlast_o, axi_rvalid_o, axi_rready_i;
    logic        iob_avalid_o, iob_ready_i, iob_rvalid_i;
    logic [31:0] iob_addr_o, iob_wdata_o, iob_rdata_i;

    always #5 clk_i = ~clk_i;

    axi_burst2iob dut (
        .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
        .axi_awid_i(axi_awid_i), .axi_awaddr_i(axi_awaddr_i), .axi_awlen_i(axi_awlen_i),
        .axi_awsize_i(axi_awsize_i), .axi_awburst_i(axi_awburst_i),
        .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
        .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i), .axi_wlast_i(axi_wlast_i),
        .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
        .axi_bid_o(axi_bid_o), .axi_bresp_o(axi_bresp_o), .axi_bvalid_o(axi_bvalid_o),
        .axi_bready_i(axi_bready_i),
        .axi_arid_i(axi_arid_i), .axi_araddr_i(axi_araddr_i), .axi_arlen_i(axi_arlen_i),
        .axi_arsize_i(axi_arsize_i), .axi_arburst_i(axi_arburst_i),
        .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
        .axi_rid_o(axi_rid_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
        .axi_rlast_o(axi_rlast_o), .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i),
        .iob_avalid_o(iob_avalid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
        .iob_wstrb_o(iob_wstrb_o), .iob_ready_i(iob_ready_i), .iob_rvalid_i(iob_rvalid_i),
        .iob_rdata_i(iob_rdata_i)
    );

    typedef struct packed {
        logic             wr;
        logic             bad_wlast;
        logic [0:0]       id;
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [1:0]       exp_resp;
        logic [8:0]       exp_n;
        logic [0:3][31:0] exp_addr;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_wdata[$];
    logic [3:0]  log_wstrb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    function automatic logic [31:0] wdat(input int beat);
        return 32'hDEADBEEF + 32'(beat) * 32'h0101_0101;
    endfunction

    function automatic vec_t mk(input logic wr, input logic bad, input logic id,
                                input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst,
                                input logic [1:0] resp, input logic [8:0] n,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [31:0] a3);
        vec_t v;
        v.wr = wr; v.bad_wlast = bad; v.id = id; v.addr = addr; v.len = len;
        v.size = size; v.burst = burst; v.exp_resp = resp; v.exp_n = n;
        v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2; v.exp_addr[3] = a3;
        return v;
    endfunction

    // IOb slave: accepts one cycle after a request appears, read data two cycles after accept.
    initial begin
        bit seen;
        int rd_cnt;
        logic [31:0] rd_addr;
        seen = 0; rd_cnt = 0; rd_addr = '0;
        iob_ready_i = 1'b0; iob_rvalid_i = 1'b0; iob_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            if (arst_i) begin
                seen = 0; rd_cnt = 0;
                iob_ready_i = 1'b0; iob_rvalid_i = 1'b0; iob_rdata_i = '0;
            end else begin
                if (rd_cnt > 0) begin
                    rd_cnt--;
                    iob_rvalid_i = (rd_cnt == 1);
                    iob_rdata_i  = (rd_cnt == 1) ? mem(rd_addr) : 32'h0;
                end
                if (iob_ready_i) begin
                    iob_ready_i = 1'b0;
                    seen = 0;
                end else if (iob_avalid_o) begin
                    if (seen) begin
                        iob_ready_i = 1'b1;
                        log_addr.push_back(iob_addr_o);
                        log_wdata.push_back(iob_wdata_o);
                        log_wstrb.push_back(iob_wstrb_o);
                        if (iob_wstrb_o == 4'h0) begin
                            rd_cnt  = 3;
                            rd_addr = iob_addr_o;
                        end
                    end else begin
                        seen = 1;
                    end
                end else begin
                    seen = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic mid();
        @(negedge clk_i); #1;
    endtask

    function automatic logic rdy(input int which);
        case (which)
            0:       return axi_awready_o;
            1:       return axi_arready_o;
            2:       return axi_wready_o;
            3:       return axi_bvalid_o;
            default: return axi_rvalid_o;
        endcase
    endfunction

    // Returns mid-cycle when the signal is seen, so a handshake lands on the next edge.
    task automatic wait_for(input int which, output bit ok);
        ok = 0;
        for (int n = 0; n < TMO && !ok; n++) begin
            mid();
            ok = rdy(which);
            if (!ok) tick();
        end
    endtask

    task automatic set_aw(input vec_t v);
        axi_awid_i = v.id; axi_awaddr_i = v.addr; axi_awlen_i = v.len;
        axi_awsize_i = v.size; axi_awburst_i = v.burst;
    endtask

    task automatic set_ar(input vec_t v);
        axi_arid_i = v.id; axi_araddr_i = v.addr; axi_arlen_i = v.len;
        axi_arsize_i = v.size; axi_arburst_i = v.burst;
    endtask

    task automatic do_w_b(input vec_t v);
        bit ok;
        log_addr.delete(); log_wdata.delete(); log_wstrb.delete();
        for (int beat = 0; beat <= int'(v.len); beat++) begin
            axi_wvalid_i = 1'b1;
            axi_wdata_i  = wdat(beat);
            axi_wstrb_i  = (beat == 0) ? 4'hF : 4'h3;
            axi_wlast_i  = v.bad_wlast ? 1'b1 : (beat == int'(v.len));
            wait_for(2, ok);
            check("w_handshake", ok, 1'b1);
            tick();
            axi_wvalid_i = 1'b0;
            axi_wlast_i  = 1'b0;
            if (!ok) break;
        end
        axi_bready_i = 1'b0;
        wait_for(3, ok);
        check("bvalid", ok, 1'b1);
        check("bid", axi_bid_o, v.id);
        check("bresp", axi_bresp_o, v.exp_resp);
        tick(); mid();
        check("b_hold_valid", axi_bvalid_o, 1'b1);
        check("b_hold_resp", axi_bresp_o, v.exp_resp);
        axi_bready_i = 1'b1;
        tick();
        axi_bready_i = 1'b0;
        check("w_iob_count", log_addr.size(), v.exp_n);
        for (int i = 0; i < 4 && i < int'(v.exp_n) && i < log_addr.size(); i++) begin
            check("w_iob_addr", log_addr[i], v.exp_addr[i]);
            check("w_iob_wdata", log_wdata[i], wdat(i));
            check("w_iob_wstrb", log_wstrb[i], (i == 0) ? 4'hF : 4'h3);
        end
    endtask

    task automatic do_r(input vec_t v, input int nbeats);
        bit ok;
        logic [31:0] exp_a, exp_d;
        log_addr.delete(); log_wdata.delete(); log_wstrb.delete();
        for (int beat = 0; beat < nbeats; beat++) begin
            axi_rready_i = 1'b0;
            wait_for(4, ok);
            check("rvalid", ok, 1'b1);
            if (!ok) break;
            // Beyond the tabulated addresses only word-stepped INCR bursts are used.
            exp_a = (beat < 4) ? v.exp_addr[beat] : v.addr + 32'(beat) * 32'd4;
            exp_d = (v.exp_resp == 2'b10) ? 32'h0 : mem(exp_a);
            check("rdata", axi_rdata_o, exp_d);
            check("rresp", axi_rresp_o, v.exp_resp);
            check("rid", axi_rid_o, v.id);
            check("rlast", axi_rlast_o, beat == int'(v.len));
            if (beat % 2 == 1) begin
                tick(); mid();
                check("r_hold_valid", axi_rvalid_o, 1'b1);
                check("r_hold_data", axi_rdata_o, exp_d);
            end
            axi_rready_i = 1'b1;
            tick();
            axi_rready_i = 1'b0;
        end
        if (nbeats == int'(v.len) + 1) begin
            check("r_iob_count", log_addr.size(), v.exp_n);
            for (int i = 0; i < 4 && i < int'(v.exp_n) && i < log_addr.size(); i++) begin
                check("r_iob_addr", log_addr[i], v.exp_addr[i]);
                check("r_iob_wstrb", log_wstrb[i], 4'h0);
            end
        end
    endtask

    task automatic run_write(input vec_t v);
        bit ok;
        set_aw(v);
        axi_awvalid_i = 1'b1;
        wait_for(0, ok);
        check("aw_handshake", ok, 1'b1);
        tick();
        axi_awvalid_i = 1'b0;
        do_w_b(v);
    endtask

    task automatic run_read(input vec_t v, input int nbeats);
        bit ok;
        set_ar(v);
        axi_arvalid_i = 1'b1;
        wait_for(1, ok);
        check("ar_handshake", ok, 1'b1);
        tick();
        axi_arvalid_i = 1'b0;
        do_r(v, nbeats);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"}, axi_awready_o, 1'b0);
        check({tag, "_arready"}, axi_arready_o, 1'b0);
        check({tag, "_wready"},  axi_wready_o,  1'b0);
        check({tag, "_bvalid"},  axi_bvalid_o,  1'b0);
        check({tag, "_rvalid"},  axi_rvalid_o,  1'b0);
        check({tag, "_avalid"},  iob_avalid_o,  1'b0);
        check({tag, "_bid"},     axi_bid_o,     1'b0);
        check({tag, "_rid"},     axi_rid_o,     1'b0);
        check({tag, "_bresp"},   axi_bresp_o,   2'b00);
        check({tag, "_rresp"},   axi_rresp_o,   2'b00);
        check({tag, "_rdata"},   axi_rdata_o,   32'h0);
        check({tag, "_rlast"},   axi_rlast_o,   1'b0);
        check({tag, "_iobaddr"}, iob_addr_o,    32'h0);
    endtask

    initial begin
        vec_t vecs[9];
        vec_t va, vb, vc, vr;

        //           wr bad id addr          len    sz burst  resp   n      IOb addresses
        vecs[0] = mk(1, 0, 1, 32'h100,  8'd0,   3'd2, 2'b01, 2'b00, 9'd1,   32'h100, 32'h0,   32'h0,   32'h0);
        vecs[1] = mk(0, 0, 0, 32'h200,  8'd3,   3'd2, 2'b01, 2'b00, 9'd4,   32'h200, 32'h204, 32'h208, 32'h20C);
        vecs[2] = mk(0, 0, 1, 32'h38,   8'd3,   3'd2, 2'b10, 2'b00, 9'd4,   32'h38,  32'h3C,  32'h30,  32'h34);
        vecs[3] = mk(1, 0, 0, 32'h40,   8'd1,   3'd2, 2'b11, 2'b10, 9'd0,   32'h0,   32'h0,   32'h0,   32'h0);
        vecs[4] = mk(0, 0, 1, 32'h80,   8'd2,   3'd3, 2'b01, 2'b10, 9'd0,   32'h0,   32'h0,   32'h0,   32'h0);
        vecs[5] = mk(1, 1, 1, 32'h300,  8'd1,   3'd2, 2'b01, 2'b10, 9'd1,   32'h300, 32'h0,   32'h0,   32'h0);
        vecs[6] = mk(1, 0, 0, 32'h500,  8'd2,   3'd2, 2'b00, 2'b00, 9'd3,   32'h500, 32'h500, 32'h500, 32'h0);
        vecs[7] = mk(0, 0, 0, 32'h10,   8'd3,   3'd1, 2'b01, 2'b00, 9'd4,   32'h10,  32'h12,  32'h14,  32'h16);
        vecs[8] = mk(0, 0, 1, 32'h1000, 8'd255, 3'd2, 2'b01, 2'b00, 9'd256, 32'h1000, 32'h1004, 32'h1008, 32'h100C);

        // NOTE: bench stimulus uses blocking assignments, applied away from the sampling edge.
        cke_i = 1'b1; arst_i = 1'b1;
        axi_awid_i = '0; axi_awaddr_i = '0; axi_awlen_i = '0; axi_awsize_i = '0;
        axi_awburst_i = '0; axi_awvalid_i = 1'b0;
        axi_wdata_i = '0; axi_wstrb_i = '0; axi_wlast_i = 1'b0; axi_wvalid_i = 1'b0;
        axi_bready_i = 1'b0;
        axi_arid_i = '0; axi_araddr_i = '0; axi_arlen_i = '0; axi_arsize_i = '0;
        axi_arburst_i = '0; axi_arvalid_i = 1'b0; axi_rready_i = 1'b0;

        repeat (3) tick();
        check_all_zero("reset");
        arst_i = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wr) run_write(vecs[i]);
            else            run_read(vecs[i], int'(vecs[i].len) + 1);
        end

        // Simultaneous requests right after reset: write first, then read, then the pending write.
        arst_i = 1'b1; tick(); arst_i = 1'b0; tick();
        va = mk(1, 0, 1, 32'h600, 8'd1, 3'd2, 2'b01, 2'b00, 9'd2, 32'h600, 32'h604, 32'h0, 32'h0);
        vb = mk(0, 0, 0, 32'h700, 8'd0, 3'd2, 2'b01, 2'b00, 9'd1, 32'h700, 32'h0,   32'h0, 32'h0);
        vc = mk(1, 0, 0, 32'h800, 8'd0, 3'd2, 2'b00, 2'b00, 9'd1, 32'h800, 32'h0,   32'h0, 32'h0);
        set_aw(va); set_ar(vb);
        axi_awvalid_i = 1'b1; axi_arvalid_i = 1'b1;
        mid();
        check("arb1_awready", axi_awready_o, 1'b1);
        check("arb1_arready", axi_arready_o, 1'b0);
        tick();
        axi_awvalid_i = 1'b0;
        do_w_b(va);
        set_aw(vc);
        axi_awvalid_i = 1'b1;
        mid();
        check("arb2_arready", axi_arready_o, 1'b1);
        check("arb2_awready", axi_awready_o, 1'b0);
        tick();
        axi_arvalid_i = 1'b0;
        do_r(vb, 1);
        mid();
        check("arb3_awready", axi_awready_o, 1'b1);
        tick();
        axi_awvalid_i = 1'b0;
        do_w_b(vc);

        // Reset after beat 1 of a 4-beat read abandons it; a fresh read then runs normally.
        vr = mk(0, 0, 1, 32'h200, 8'd3, 3'd2, 2'b01, 2'b00, 9'd4, 32'h200, 32'h204, 32'h208, 32'h20C);
        run_read(vr, 2);
        check("pre_rst_avalid", iob_avalid_o, 1'b1);
        arst_i = 1'b1;
        #1;
        check_all_zero("midrst");
        tick();
        arst_i = 1'b0;
        tick();
        run_read(vecs[1], 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_burst2iob.md
Name: axi_burst2iob

Overview:
Bridge from a full AXI4 slave port to a single IOb-bus master port. It sits between the peripheral master port of the system AXI interconnect and the peripheral iob_split. It replaces the AXI-Lite bridge on that path so that bursts, IDs and RLAST are handled correctly rather than tied off. Each AXI beat becomes one IOb access. One AXI transaction is in flight at a time.

Parameters:
ADDR_W, 32, AXI and IOb address width
DATA_W, 32, AXI and IOb data width (power of two, >=8)
AXI_ID_W, 1, AXI ID width
AXI_LEN_W, 8, AXI burst length field width

Ports:
clk_i  in  1  system clock
cke_i  in  1  clock enable; when low, all registers hold their value
arst_i  in  1  asynchronous reset, active high
axi_awid_i/awaddr_i/awlen_i/awsize_i/awburst_i  in  ID_W/ADDR_W/LEN_W/3/2  AXI write address
axi_awvalid_i  in  1 ; axi_awready_o  out  1  write address handshake
axi_wdata_i/wstrb_i/wlast_i  in  DATA_W/DATA_W/8/1  write data
axi_wvalid_i  in  1 ; axi_wready_o  out  1  write data handshake
axi_bid_o/bresp_o  out  ID_W/2 ; axi_bvalid_o  out  1 ; axi_bready_i  in  1  write response
axi_arid_i/araddr_i/arlen_i/arsize_i/arburst_i  in  ID_W/ADDR_W/LEN_W/3/2  AXI read address
axi_arvalid_i  in  1 ; axi_arready_o  out  1  read address handshake
axi_rid_o/rdata_o/rresp_o/rlast_o  out  ID_W/DATA_W/2/1 ; axi_rvalid_o  out  1 ; axi_rready_i  in  1  read data
iob_avalid_o  out  1  IOb request valid
iob_addr_o  out  ADDR_W  IOb address
iob_wdata_o  out  DATA_W  IOb write data
iob_wstrb_o  out  DATA_W/8  IOb write strobe; all zero means read
iob_ready_i  in  1  IOb request accepted
iob_rvalid_i  in  1  IOb read data valid
iob_rdata_i  in  DATA_W  IOb read data

Behaviour:
- Clock and reset: one clock, clk_i. arst_i is asynchronous and active high.
- Reset values: every valid and ready output is 0; bid, rid, bresp, rresp, rdata, rlast and iob_addr are 0; the FSM is in IDLE; the arbitration pointer favours write.
- A reset in the middle of a burst abandons the burst immediately. No B or R beat is produced for it.
- FSM states: IDLE, WR_DATA, WR_RESP, RD_REQ, RD_WAIT, RD_DATA.
- IDLE:
  - awready_o = 1 only when the write is the selected request; arready_o = 1 only when the read is the selected request.
  - If only one of awvalid/arvalid is high, that request is selected.
  - If both are high, the side named by the pointer is selected, and the pointer then flips to the other side.
  - On the handshake, latch ID, address, len, size and burst, and clear the beat counter and the error flag.
  - Next state is WR_DATA or RD_REQ.
- Error check: the error flag is set at the handshake if burst==2'b11, or if 2^size > DATA_W/8.
- Address step = 2^size.
  - FIXED: the address does not change.
  - INCR: address += step after each beat.
  - WRAP: address += step, wrapping within an aligned window of (len+1)*step bytes.
- WR_DATA, no error:
  - iob_avalid_o = wvalid_i; iob_wdata_o = wdata_i; iob_wstrb_o = wstrb_i.
  - wready_o = iob_ready_i.
  - A beat completes on wvalid && iob_ready_i.
- WR_DATA, error:
  - wready_o = 1 and iob_avalid_o = 0, so W beats are drained without any IOb access.
- Write beat end:
  - On the beat where counter==len, go to WR_RESP.
  - If wlast disagrees with counter==len on any beat, set the error flag. The burst length always follows len.
- WR_RESP: bvalid_o = 1, bid_o = the latched ID, bresp_o = 2'b10 if error else 2'b00. Hold until bready_i, then go to IDLE.
- RD_REQ:
  - No error: iob_avalid_o = 1 with wstrb = 0 until iob_ready_i, then go to RD_WAIT.
  - Error: skip the IOb access, load rdata = 0 and go straight to RD_DATA.
- RD_WAIT: on iob_rvalid_i, register iob_rdata_i into rdata_o and go to RD_DATA. Latency is at least 1 cycle after iob_ready_i.
- RD_DATA:
  - rvalid_o = 1, rid_o = the latched ID, rresp_o = 2'b10 if error else 2'b00, rlast_o = (counter==len).
  - Hold until rready_i.
  - Then go to IDLE if this was the last beat; otherwise advance the address, increment the counter and go to RD_REQ.
- There is never more than one outstanding IOb request.
- rdata_o, rid_o, bid_o and the resp outputs stay stable while their valid is high and ready is low.
- len = 0 gives a single beat, with rlast = 1 on that beat.
- len = 255 must count correctly using a counter of AXI_LEN_W bits.

Test Plan:
- Single write, awaddr=0x100, len=0, size=2, wdata=0xDEADBEEF, wstrb=0xF, iob_ready 1 cycle late -> one IOb write to 0x100; bvalid with bresp=0 and bid matching awid.
- INCR read, araddr=0x200, len=3, size=2, memory model with 2-cycle rvalid latency, rready toggling -> IOb reads at 0x200/204/208/20C; 4 R beats in order; rlast only on the 4th; rdata held while rready=0.
- WRAP read, araddr=0x38, len=3, size=2 -> IOb addresses 0x38, 0x3C, 0x30, 0x34.
- Error cases:
  - Write with awburst=2'b11 -> no iob_avalid; W beats drained; bresp=2'b10.
  - Read with arsize=3 on DATA_W=32 -> 1+len beats with rresp=2'b10 and rdata=0.
- awvalid and arvalid asserted together twice in a row after reset -> write served first, then read. Write with wlast high on beat 0 of len=1 -> 2 beats consumed, bresp=2'b10.
- arst_i pulsed mid-burst (after beat 1 of len=3) -> all outputs 0 immediately; a following fresh read completes normally.
